fan_pwm_bank: RTL and testbench
===============================

# fan_pwm_bank

Multi-channel PWM fan driver with glitch-free duty updates and optional soft-start ramping. One shared frame counter with a programmable period drives CHANNELS independent duty comparators. Per-channel targets are written through a simple strobe port from the smart-home controller. Each output moves toward its target only at frame boundaries, either immediately or one step per RAMP_DIV frames.

## Interface
- WIDTH, 8, bit width of the counter, period and duty values.
- CHANNELS, 4, number of PWM outputs (≥1).
- RAMP_DIV, 16, number of frames per ramp step (≥1).
- CHW, derived, channel-index width: max(1, $clog2(CHANNELS)).

- clk  in  1  clock, rising edge.
- arst  in  1  reset, asynchronous, active-high.
- period  in  WIDTH  frame length minus 1; sampled only at frame wrap.
- speed_wr  in  1  write strobe for one channel target.
- speed_ch  in  CHW  channel index for the write.
- speed_data  in  WIDTH  new target duty.
- ramp_en  in  1  1 = ramp current duty one LSB per step; 0 = jump to target at next wrap.
- pwm_out  out  CHANNELS  registered PWM outputs.
- busy  out  CHANNELS  registered; bit c = 1 while cur[c] ≠ target[c].
- wrap  out  1  registered one-cycle pulse marking the last cycle of each frame.

## Operation
- Registers: cnt, period_q (WIDTH); target[c], cur[c] (WIDTH); frame_div (counts 0..RAMP_DIV-1).
- Counter: while cnt ≠ period_q, cnt increments by 1. When cnt == period_q, this is a wrap cycle: cnt ← 0 and period_q ← period. A frame is therefore period_q+1 cycles long. If period_q = 0, every cycle is a wrap.
- Compare: pwm_out[c] ← (cnt < cur[c]), unsigned.
  - cur = 0 gives a constant low output.
  - cur > period_q gives a constant high output.
  - Otherwise the output is high for cur cycles of each frame.
- Write: if speed_wr and speed_ch < CHANNELS, target[speed_ch] ← speed_data. Out-of-range indices are ignored. Back-to-back writes: the last one wins.
- Duty update happens only in a wrap cycle. Ramp step condition: frame_div == RAMP_DIV-1. frame_div increments on each wrap and wraps to 0 after RAMP_DIV-1.
  - ramp_en = 0: cur[c] ← target[c].
  - ramp_en = 1 and step condition true: cur[c] moves one LSB toward target[c] (±1), saturating at target. No change if equal.
  - ramp_en = 1 and step condition false: cur holds.
- Simultaneous write and wrap: the wrap-cycle update uses the pre-write target. The new target is applied from the following wrap.
- A ramp_en change takes effect at the next wrap. A change 1→0 mid-ramp jumps cur to target at that wrap.
- busy[c] ← (cur_next[c] ≠ target_next[c]), i.e. it reflects register state after the same clock edge.
- wrap ← (cnt == period_q).

## Timing
- Reset (arst = 1, asynchronous, no clock required): all of the following clear immediately.
  - cnt = 0, frame_div = 0, target = 0, cur = 0.
  - pwm_out = 0, busy = 0, wrap = 0.
  - period_q = all-ones (2^WIDTH-cycle frame).
- Reset release: cnt = 0 on the first active edge. The first wrap is asserted at cnt = period_q, i.e. 2^WIDTH cycles after release.
- Output latency: pwm_out and wrap lag cnt by one cycle (registered compare).
- Write to pwm effect:
  - ramp_en = 0: the new duty is visible from the first frame after the next wrap, then pwm_out one cycle later.
  - ramp_en = 1: the first step waits for the next step wrap. A full ramp of Δ LSBs takes up to Δ·RAMP_DIV frames.
- Period change latency: the new period governs the frame that starts after the current wrap. The current frame is never truncated.
- No duty or period change ever occurs mid-frame, so no runt pulses.

## Test plan
1. WIDTH=8, CHANNELS=4, period=255, ramp_en=0; after reset write ch0=64 → after the next wrap, pwm_out[0] is high exactly 64 of every 256 cycles; pwm_out[3:1]=0; busy[0] is high only until that wrap.
2. period=99, ch1=0, ch2=200, ch3=100 → pwm_out[1] constant 0, pwm_out[2] constant 1, pwm_out[3] constant 1 (100 > 99); wrap pulses every 100 cycles.
3. RAMP_DIV=2, ramp_en=1, period=9, write ch1=3 → cur[1] steps 0→1→2→3, one step every 2 frames (20 cycles); busy[1] falls when cur=3; then write ch1=0 → it ramps down symmetrically.
4. period changed 255→9 while cnt=100 → current frame completes to 255; wrap then occurs every 10 cycles; a write issued in the wrap cycle applies one frame later.
5. CHANNELS=3, write speed_ch=3 data=50 → no target changes; busy stays 0.
6. Mid-ramp (cur[1]=2, target 3), assert arst between edges → all outputs are 0 before the next clk edge; after release, period_q=255 and the first wrap occurs 256 cycles later.

Source files
------------

// File: rtl/fan_pwm_bank.sv
// Multi-channel PWM fan driver: shared frame counter, per-channel duty lanes with
// frame-aligned duty updates and optional one-LSB-per-step soft-start ramping.

module fan_pwm_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_wrap,
    input  logic             i_step,
    input  logic             i_ramp_en,
    input  logic [WIDTH-1:0] i_cnt,
    output logic             o_pwm,
    output logic             o_busy
);
    logic [WIDTH-1:0] r_tgt, r_cur;
    logic [WIDTH-1:0] w_tgt_nxt, w_cur_nxt;

    // The wrap update reads r_tgt, so a write landing on the wrap cycle waits a frame.
    always_comb begin
        w_tgt_nxt = i_wr ? i_data : r_tgt;
        w_cur_nxt = r_cur;
        if (i_wrap) begin
            if (!i_ramp_en) begin
                w_cur_nxt = r_tgt;
            end else if (i_step) begin
                if (r_cur < r_tgt)
                    w_cur_nxt = r_cur + 1'b1;
                else if (r_cur > r_tgt)
                    w_cur_nxt = r_cur - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_tgt  <= '0;
            r_cur  <= '0;
            o_pwm  <= 1'b0;
            o_busy <= 1'b0;
        end else begin
            r_tgt  <= w_tgt_nxt;
            r_cur  <= w_cur_nxt;
            o_pwm  <= (i_cnt < r_cur);
            o_busy <= (w_cur_nxt != w_tgt_nxt);
        end
    end
endmodule

module fan_pwm_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int RAMP_DIV = 16,
    localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [WIDTH-1:0]    period,
    input  logic                speed_wr,
    input  logic [CHW-1:0]      speed_ch,
    input  logic [WIDTH-1:0]    speed_data,
    input  logic                ramp_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic [CHANNELS-1:0] busy,
    output logic                wrap
);
    localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [WIDTH-1:0] r_cnt, r_period_q;
    logic [DW-1:0]    r_frame_div;
    logic             w_wrap, w_step;

    assign w_wrap = (r_cnt == r_period_q);
    assign w_step = (r_frame_div == DW'(RAMP_DIV - 1));

    // period is only sampled at the wrap, so a frame in progress is never truncated.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_cnt       <= '0;
            r_period_q  <= '1;
            r_frame_div <= '0;
            wrap        <= 1'b0;
        end else begin
            wrap <= w_wrap;
            if (w_wrap) begin
                r_cnt       <= '0;
                r_period_q  <= period;
                r_frame_div <= w_step ? '0 : r_frame_div + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Out-of-range channel indices match no lane and are dropped.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        fan_pwm_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .arst     (arst),
            .i_wr     (speed_wr && (speed_ch == CHW'(c))),
            .i_data   (speed_data),
            .i_wrap   (w_wrap),
            .i_step   (w_step),
            .i_ramp_en(ramp_en),
            .i_cnt    (r_cnt),
            .o_pwm    (pwm_out[c]),
            .o_busy   (busy[c])
        );
    end
endmodule

// File: tb/tb_fan_pwm_bank.sv
// Directed bench for fan_pwm_bank: frame-level model checked every cycle plus
// hand-computed duty, period, ramp and reset expectations.

module tb_fan_pwm_bank;
    localparam int W   = 8;
    localparam int NCH = 3;
    localparam int RD  = 2;
    localparam int CHW = 2;

    logic           clk = 1'b0;
    logic           arst;
    logic [W-1:0]   period;
    logic           speed_wr;
    logic [CHW-1:0] speed_ch;
    logic [W-1:0]   speed_data;
    logic           ramp_en;
    logic [NCH-1:0] pwm_out, busy;
    logic           wrap;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    fan_pwm_bank #(.WIDTH(W), .CHANNELS(NCH), .RAMP_DIV(RD)) dut (
        .clk(clk), .arst(arst), .period(period), .speed_wr(speed_wr),
        .speed_ch(speed_ch), .speed_data(speed_data), .ramp_en(ramp_en),
        .pwm_out(pwm_out), .busy(busy), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Frame-level model: duty and period only move at the end of a frame.
    int m_cnt, m_pq, m_fd;
    int m_tgt[NCH], m_cur[NCH];
    logic [NCH-1:0] e_pwm, e_busy;
    logic e_wrap;

    always @(posedge clk or posedge arst) begin : model
        int nt[NCH];
        bit last;
        if (arst) begin
            m_cnt = 0; m_pq = (1 << W) - 1; m_fd = 0;
            for (int c = 0; c < NCH; c++) begin m_tgt[c] = 0; m_cur[c] = 0; end
            e_pwm = '0; e_busy = '0; e_wrap = 1'b0;
        end else begin
            last = (m_cnt == m_pq);
            for (int c = 0; c < NCH; c++) e_pwm[c] = (m_cnt < m_cur[c]);
            e_wrap = last;
            nt = m_tgt;
            if (speed_wr && int'(speed_ch) < NCH) nt[int'(speed_ch)] = int'(speed_data);
            if (last) begin
                for (int c = 0; c < NCH; c++) begin
                    if (!ramp_en) m_cur[c] = m_tgt[c];
                    else if (m_fd == RD - 1) begin
                        if (m_cur[c] < m_tgt[c]) m_cur[c]++;
                        else if (m_cur[c] > m_tgt[c]) m_cur[c]--;
                    end
                end
                m_fd  = (m_fd + 1) % RD;
                m_pq  = int'(period);
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
            m_tgt = nt;
            for (int c = 0; c < NCH; c++) e_busy[c] = (m_cur[c] != m_tgt[c]);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_pwm",  int'(pwm_out), int'(e_pwm));
            chk("cyc_busy", int'(busy),    int'(e_busy));
            chk("cyc_wrap", int'(wrap),    int'(e_wrap));
        end
    end

    task automatic wr(input int ch, input int d);
        @(negedge clk); #1;
        speed_wr = 1'b1; speed_ch = CHW'(ch); speed_data = W'(d);
        @(negedge clk); #1;
        speed_wr = 1'b0;
    endtask

    task automatic wait_wrap(input string name, input int bound, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!wrap && n < bound);
        if (!wrap) chk({name, "_timeout"}, n, -1);
    endtask

    task automatic count_high(input int cycles, input int ch, output int h);
        h = 0;
        for (int i = 0; i < cycles; i++) begin @(negedge clk); h += int'(pwm_out[ch]); end
    endtask

    int n, h, hb;

    initial begin
        arst = 1'b0; period = 8'd255; speed_wr = 1'b0; speed_ch = '0;
        speed_data = '0; ramp_en = 1'b0;
        #1 arst = 1'b1;
        #2;
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wrap", int'(wrap), 0);
        @(negedge clk); @(negedge clk); #1 arst = 1'b0;
        chk_en = 1;

        // 1: 64/256 duty with immediate update at the frame boundary
        wr(0, 64);
        chk("t1_busy_after_wr", int'(busy[0]), 1);
        wait_wrap("t1_wrap", 400, n);
        chk("t1_first_wrap", n, 256 - 2);
        chk("t1_busy_clear", int'(busy[0]), 0);
        h = 0; hb = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk); h += int'(pwm_out[0]); hb += int'(pwm_out[1]) + int'(pwm_out[2]);
        end
        chk("t1_ch0_high", h, 64);
        chk("t1_other_high", hb, 0);
        chk("t1_frame_end_wrap", int'(wrap), 1);

        // 2: period 99, constant low / constant high cases
        period = 8'd99;
        wr(1, 0); wr(2, 200); wr(0, 100);
        wait_wrap("t2_wrap", 300, n);
        count_high(100, 0, h);
        chk("t2_ch0_high", h, 100);
        chk("t2_wrap_at_100", int'(wrap), 1);
        wait_wrap("t2_wrap2", 200, n);
        chk("t2_wrap_interval", n, 100);
        count_high(100, 2, h);
        chk("t2_ch2_high", h, 100);
        count_high(100, 1, h);
        chk("t2_ch1_high", h, 0);

        // 3: ramp up 0->3 then down, one step per 2 frames of 10 cycles
        ramp_en = 1'b1; period = 8'd9;
        wait_wrap("t3_wrap", 200, n);
        wr(1, 3);
        chk("t3_busy_rise", int'(busy[1]), 1);
        n = 0;
        while (busy[1] && n < 200) begin @(negedge clk); n++; end
        chk("t3_ramp_up_bounded", int'(n >= 38 && n <= 62), 1);
        wait_wrap("t3_wrap_up", 20, n);
        count_high(10, 1, h);
        chk("t3_ch1_duty3", h, 3);
        wr(1, 0);
        chk("t3_busy_rise_dn", int'(busy[1]), 1);
        n = 0;
        while (busy[1] && n < 200) begin @(negedge clk); n++; end
        chk("t3_ramp_dn_bounded", int'(n >= 38 && n <= 62), 1);
        wait_wrap("t3_wrap_dn", 20, n);
        count_high(10, 1, h);
        chk("t3_ch1_duty0", h, 0);

        // 4: write landing on the wrap cycle is applied one frame later
        ramp_en = 1'b0;
        wait_wrap("t4_wrap", 20, n);
        repeat (9) @(negedge clk);
        #1 speed_wr = 1'b1; speed_ch = 2'd1; speed_data = 8'd5;
        @(negedge clk); #1 speed_wr = 1'b0;
        hb = 0;
        for (int i = 0; i < 12; i++) begin
            hb += int'(busy[1]);
            @(negedge clk);
        end
        chk("t4_busy_one_frame", hb, 10);

        // 5: out-of-range channel write is ignored
        wr(3, 50);
        hb = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); hb += int'(busy != 0); end
        chk("t5_no_busy", hb, 0);

        // 6: async reset mid-ramp, then a period change that must not truncate
        ramp_en = 1'b1;
        wr(1, 8);
        repeat (25) @(negedge clk);
        chk("t6_pre_rst_pwm_nonzero", int'(pwm_out != 0), 1);
        @(posedge clk); #2 arst = 1'b1;
        #1;
        chk("t6_rst_pwm", int'(pwm_out), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_wrap", int'(wrap), 0);
        period = 8'd255;
        @(posedge clk); @(negedge clk); #1 arst = 1'b0;
        repeat (100) @(negedge clk);
        #1 period = 8'd9;
        wait_wrap("t6_wrap", 300, n);
        chk("t6_first_wrap", n + 100, 256);
        wait_wrap("t6_wrap2", 50, n);
        chk("t6_new_period", n, 10);
        wait_wrap("t6_wrap3", 50, n);
        chk("t6_new_period2", n, 10);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
